// File: rtl/debug_host_pkg.sv
// Shared encodings for the CPU debug-port host: command ops, debug codes, FSM states.
// Debug code values mirror the CPU-side io_control decoder.
package debug_host_pkg;

   localparam int DEBUG_WIDTH = 3;
   localparam int PC_WIDTH    = 32;
   localparam int DATA_WIDTH  = 32;
   localparam int IADDR_WIDTH = 10;
   localparam int RADDR_WIDTH = 5;
   localparam int DADDR_WIDTH = 10;

   localparam int CNT_W = 4;

   localparam logic [2:0] DBG_OP_PCRD  = 3'd0;
   localparam logic [2:0] DBG_OP_ICRD  = 3'd1;
   localparam logic [2:0] DBG_OP_ICWR  = 3'd2;
   localparam logic [2:0] DBG_OP_REGRD = 3'd3;
   localparam logic [2:0] DBG_OP_DCRD  = 3'd4;

   localparam logic [2:0] DEBUG_IDLE  = 3'd0;
   localparam logic [2:0] DEBUG_PCRD  = 3'd1;
   localparam logic [2:0] DEBUG_ICRD  = 3'd2;
   localparam logic [2:0] DEBUG_ICWR  = 3'd3;
   localparam logic [2:0] DEBUG_REGRD = 3'd4;
   localparam logic [2:0] DEBUG_DCRD  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CAPT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= DBG_OP_DCRD);
   endfunction

   function automatic logic [2:0] op_to_debug(input logic [2:0] op);
      logic [2:0] code;
      code = DEBUG_IDLE;
      case (op)
         DBG_OP_PCRD:  code = DEBUG_PCRD;
         DBG_OP_ICRD:  code = DEBUG_ICRD;
         DBG_OP_ICWR:  code = DEBUG_ICWR;
         DBG_OP_REGRD: code = DEBUG_REGRD;
         DBG_OP_DCRD:  code = DEBUG_DCRD;
         default:      code = DEBUG_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/debug_host.sv
// Host-side sequencer for the CPU debug port: one command in, one response out.
// Holds each debug code long enough for the CPU-side rdata register to settle, then captures it.
module debug_host
   import debug_host_pkg::*;
#(
   parameter int DEBUG_W = 3,
   parameter int DATA_W  = 32,
   parameter int IADDR_W = 10,
   parameter int RADDR_W = 5,
   parameter int DADDR_W = 10,
   parameter int RD_LAT  = 3,
   parameter int WR_LAT  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [IADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0]  cmd_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_err,
   output logic [DEBUG_W-1:0] debug,
   output logic [IADDR_W-1:0] icache_addr,
   output logic [DATA_W-1:0]  icache_wdata,
   output logic [RADDR_W-1:0] reg_raddr,
   output logic [DADDR_W-1:0] dcache_raddr,
   input  logic [DATA_W-1:0]  pc_i,
   input  logic [DATA_W-1:0]  icache_rdata_i,
   input  logic [DATA_W-1:0]  reg_rdata_i,
   input  logic [DATA_W-1:0]  dcache_rdata_i
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   logic             w_accept;
   logic             w_legal;
   logic             w_drive_done;

   assign cmd_ready    = (r_state == S_IDLE);
   assign rsp_valid    = (r_state == S_RESP);
   assign w_accept     = cmd_valid && cmd_ready;
   assign w_legal      = op_legal(cmd_op);
   assign w_drive_done = (r_op == DBG_OP_ICWR) ? (r_cnt == CNT_W'(WR_LAT - 1))
                                               : (r_cnt == CNT_W'(RD_LAT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_legal ? S_DRIVE : S_RESP;
         S_DRIVE: if (w_drive_done) w_next = S_CAPT;
         S_CAPT:  w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Address outputs are written only on accept so they stay driven after completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_op         <= DBG_OP_PCRD;
         debug        <= DEBUG_W'(DEBUG_IDLE);
         icache_addr  <= '0;
         icache_wdata <= '0;
         reg_raddr    <= '0;
         dcache_raddr <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op  <= cmd_op;
                  r_cnt <= '0;
                  if (w_legal) begin
                     debug <= DEBUG_W'(op_to_debug(cmd_op));
                     case (cmd_op)
                        DBG_OP_ICRD:  icache_addr <= cmd_addr;
                        DBG_OP_ICWR: begin
                           icache_addr  <= cmd_addr;
                           icache_wdata <= cmd_wdata;
                        end
                        DBG_OP_REGRD: reg_raddr    <= cmd_addr[RADDR_W-1:0];
                        DBG_OP_DCRD:  dcache_raddr <= DADDR_W'(cmd_addr);
                        default: ;
                     endcase
                  end else begin
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                  end
               end
            end
            S_DRIVE: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_drive_done) debug <= DEBUG_W'(DEBUG_IDLE);
            end
            S_CAPT: begin
               case (r_op)
                  DBG_OP_PCRD:  rsp_data <= pc_i;
                  DBG_OP_ICRD:  rsp_data <= icache_rdata_i;
                  DBG_OP_REGRD: rsp_data <= reg_rdata_i;
                  DBG_OP_DCRD:  rsp_data <= dcache_rdata_i;
                  default:      rsp_data <= '0;
               endcase
            end
            S_RESP: begin
               if (rsp_ready) rsp_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/debug_host.md
Name: debug_host

Overview:
- Host-side sequencer for the CPU debug port; drives the debug code and external address/data inputs that io_control consumes, and collects its registered read results.
- Accepts one debug command at a time over a valid/ready channel and returns one response per command.
- Command ops: PC read, icache read, icache write, register read, dcache read.
- Sits between the test/UART front end and the CPU top's debug pins.

Parameters:
- DEBUG_W, 3: width of the debug code bus (matches `DEBUG_WIDTH).
- DATA_W, 32: data/PC width.
- IADDR_W, 10: icache word address width.
- RADDR_W, 5: register address width.
- DADDR_W, 10: dcache word address width.
- RD_LAT, 3: cycles the debug code must be held before the CPU-side rdata register holds the result (addr register + SRAM + rdata register).
- WR_LAT, 2: cycles the ICWR code is held for a write to land.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  3  0=PCRD 1=ICRD 2=ICWR 3=REGRD 4=DCRD; 5-7 illegal
- cmd_addr  in  IADDR_W  address; low RADDR_W/DADDR_W bits used for REGRD/DCRD
- cmd_wdata  in  DATA_W  icache write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  DATA_W  read result; 0 for ICWR/error
- rsp_err  out  1  illegal op
- debug  out  DEBUG_W  debug code to CPU
- icache_addr  out  IADDR_W
- icache_wdata  out  DATA_W
- reg_raddr  out  RADDR_W
- dcache_raddr  out  DADDR_W
- pc_i, icache_rdata_i, reg_rdata_i, dcache_rdata_i  in  DATA_W each  registered results from CPU

Behaviour:
- Reset values:
  - debug=`DEBUG_IDLE; all addr/wdata outputs 0; rsp_valid=0; rsp_data=0; rsp_err=0.
  - cmd_ready=1 combinationally in IDLE only; state=IDLE; counter=0.
- FSM states: IDLE, DRIVE, CAPT, RESP.
- IDLE, on cmd_valid:
  - Latch op, addr, wdata.
  - Legal op: drive the matching debug code and address/data outputs next cycle; go to DRIVE with cnt=0.
  - Illegal op: go straight to RESP with rsp_err=1, rsp_data=0; debug stays IDLE.
- DRIVE:
  - debug and addr/data held constant; cnt increments each cycle.
  - Exit when cnt==RD_LAT-1 (reads) or WR_LAT-1 (ICWR), then go to CAPT.
  - debug is therefore asserted for exactly RD_LAT or WR_LAT consecutive cycles.
- CAPT (one cycle):
  - debug=`DEBUG_IDLE.
  - rsp_data <= the rdata input selected by the latched op (PC→pc_i, ICRD→icache_rdata_i, REGRD→reg_rdata_i, DCRD→dcache_rdata_i, ICWR→0).
  - Go to RESP.
- RESP:
  - rsp_valid=1, holding rsp_data and rsp_err stable until rsp_ready.
  - On handshake, clear rsp_valid and rsp_err and go to IDLE. The next command may be accepted on the following cycle.
- Latency:
  - Read op: accept → rsp_valid is RD_LAT+2 cycles.
  - ICWR: WR_LAT+2 cycles.
  - Illegal op: 1 cycle.
- Addresses stay driven (not cleared) after completion; only debug returns to IDLE.
- icache_wdata updates only on ICWR accept.
- Width rules:
  - REGRD uses cmd_addr[RADDR_W-1:0].
  - DCRD uses cmd_addr zero-extended or truncated to DADDR_W.
- rsp_ready held low: the FSM stalls in RESP indefinitely and accepts no new command.
- cmd_valid during a non-IDLE state is ignored (cmd_ready=0).
- Reset mid-operation returns immediately to reset values. Any partially driven debug code is dropped; the CPU-side registers settle under their own reset.

Decomposition:
- Shared in define.vh:
  - Debug code macros `DEBUG_IDLE/PCRD/ICRD/ICWR/REGRD/DCRD and `DEBUG_WIDTH.
  - Width macros `PC_WIDTH, `DATA_WIDTH, `IADDR_WIDTH, `RADDR_WIDTH, `DADDR_WIDTH.
  - A new cmd_op encoding block (`DBG_OP_*).
- No sub-module; the FSM, counter and result mux fit in one file.

Test Plan:
- Reset mid-DRIVE of ICRD → next cycle debug=IDLE, rsp_valid=0, cmd_ready=1.
- ICWR addr=0x005, wdata=0xDEADBEEF → icache_addr=0x005, icache_wdata=0xDEADBEEF, debug=ICWR for exactly 2 cycles; rsp_valid at accept+4 with rsp_data=0, rsp_err=0.
- ICWR then ICRD addr=0x005, with a CPU model of io_control+SRAM → rsp_data=0xDEADBEEF at accept+5.
- REGRD addr=0x3FF with model returning 0x12345678 for x31 → reg_raddr=5'd31, rsp_data=0x12345678.
- Illegal op=6 → no debug activity; rsp_valid the next cycle with rsp_err=1, rsp_data=0.
- PCRD with rsp_ready held low for 10 cycles → rsp_valid and rsp_data stable, cmd_ready=0 throughout; a cmd_valid pulse during the stall is ignored.
